// File: rtl/vga_frame_buffer.sv
// Double-buffered 3-bit colour frame buffer between the drawing logic and the VGA scan-out.
// The back bank takes pixel writes and hardware clears; banks swap only at vertical-blank entry.
module vga_frame_buffer #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int SCREEN_X    = 640,
    parameter int SCREEN_Y    = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] posX,
    input  logic [10:0] posY,
    output logic [2:0]  pixel_out,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [2:0]  wr_color,
    input  logic        clear_req,
    input  logic [2:0]  clear_color,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swap_done,
    output logic        front_sel,
    output logic        busy
);

    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [10:0]   SX   = 11'(SCREEN_X);
    localparam logic [10:0]   SY   = 11'(SCREEN_Y);
    localparam logic [7:0]    FBX  = 8'(FB_W);
    localparam logic [6:0]    FBY  = 7'(FB_H);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [2:0]    clr_color_q, clr_color_d;
    logic          front_sel_q, front_sel_d;
    logic          swap_pending_q, swap_pending_d;
    logic          swap_done_q, swap_done_d;
    logic          vis_q, vis_d;
    logic [2:0]    rd_q;

    logic [2:0]    mem0 [DEPTH];
    logic [2:0]    mem1 [DEPTH];

    logic [10:0]   sx, sy;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          we;
    logic          vblank;

    // Scan side: downscale first so the multiply stays within the FB range
    always_comb begin
        sx      = posX >> SCALE_SHIFT;
        sy      = posY >> SCALE_SHIFT;
        vis_d   = (posX < SX) && (posY < SY);
        rd_addr = '0;
        if (vis_d) begin
            rd_addr = AW'(int'(sy) * FB_W + int'(sx));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_color_d = clr_color_q;
        we          = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        unique case (state_q)
            IDLE: begin
                if (wr_valid && (wr_x < FBX) && (wr_y < FBY)) begin
                    we      = 1'b1;
                    wr_addr = AW'(int'(wr_y) * FB_W + int'(wr_x));
                    wr_data = wr_color;
                end
                if (clear_req) begin
                    state_d     = CLEAR;
                    cnt_d       = '0;
                    clr_color_d = clear_color;
                end
            end
            CLEAR: begin
                we      = 1'b1;
                wr_addr = cnt_q;
                wr_data = clr_color_q;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // A request arriving on the vblank cycle itself is honoured immediately
    always_comb begin
        vblank         = (posY == SY) && (posX == 11'd0);
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q | swap_req;
        swap_done_d    = 1'b0;
        if (vblank && swap_pending_d && (state_q == IDLE)) begin
            front_sel_d    = ~front_sel_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            clr_color_q    <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            vis_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            clr_color_q    <= clr_color_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            vis_q          <= vis_d;
        end
    end

    // Writes always hit the bank not on screen; reads always hit the one that is
    always_ff @(posedge clk) begin
        if (we && front_sel_q) begin
            mem0[wr_addr] <= wr_data;
        end
        if (we && !front_sel_q) begin
            mem1[wr_addr] <= wr_data;
        end
        rd_q <= front_sel_q ? mem1[rd_addr] : mem0[rd_addr];
    end

    assign pixel_out    = vis_q ? rd_q : 3'b000;
    assign wr_ready     = (state_q == IDLE);
    assign busy         = (state_q == CLEAR);
    assign front_sel    = front_sel_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;

endmodule

// File: doc/vga_frame_buffer.md
Name: vga_frame_buffer

Overview:
- Double-buffered 3-bit colour frame buffer feeding the 640x480 VGA driver's pixel input.
- Game/drawing logic writes pixels into the back bank over a valid/ready port.
- The scan side converts the driver's posX/posY into a read of the front bank, upscaled by 2^SCALE_SHIFT.
- Bank swap happens only at vertical-blank entry, so there is no tearing; a hardware clear of the back bank is included.

Parameters:
- FB_W, 160, frame buffer width in pixels.
- FB_H, 120, frame buffer height in pixels.
- SCALE_SHIFT, 2, log2 of the upscale factor from FB to screen (160x120 -> 640x480).
- SCREEN_X, 640, visible screen width.
- SCREEN_Y, 480, visible screen height.

Ports:
- clk  in  1  pixel clock, same clock as the VGA driver.
- rst  in  1  asynchronous, active-high reset.
- posX  in  11  horizontal position from the VGA driver.
- posY  in  11  vertical position from the VGA driver.
- pixel_out  out  3  colour to the driver's pixelIn.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  8  write column.
- wr_y  in  7  write row.
- wr_color  in  3  write colour.
- clear_req  in  1  pulse: fill back bank with clear_color.
- clear_color  in  3  fill colour, sampled on the clear_req cycle.
- swap_req  in  1  pulse: request front/back exchange.
- swap_pending  out  1  swap requested, not yet performed.
- swap_done  out  1  one-cycle pulse when the swap takes effect.
- front_sel  out  1  bank currently displayed (0/1).
- busy  out  1  clear in progress.

Behaviour:
- Storage: two banks of FB_W*FB_H x 3 bits, inferred simple-dual-port RAM. Contents are not reset.
- Address formula: y*FB_W + x.
- Reset values: pixel_out=0, front_sel=0, swap_pending=0, swap_done=0, busy=0, wr_ready=1, FSM=IDLE, clear counter=0.
- Read path:
  - Address uses (posY>>SCALE_SHIFT, posX>>SCALE_SHIFT) in bank front_sel.
  - pixel_out is registered, with exactly 1 cycle latency from posX/posY. The top level delays the driver's sync/blank by 1 cycle to align.
  - If posX>=SCREEN_X or posY>=SCREEN_Y in the sampled cycle, pixel_out=0 on the next cycle and the RAM value is ignored.
- Write path:
  - In IDLE, wr_ready=1.
  - An accepted write stores wr_color into bank ~front_sel at (wr_x,wr_y) on that clock edge.
  - Writes with wr_x>=FB_W or wr_y>=FB_H are accepted (handshake completes) and dropped.
- FSM states:
  - IDLE: normal operation. clear_req -> CLEAR, with counter=0, colour latched, and busy=1 from the next cycle. A write on the same cycle as clear_req is performed before clearing starts.
  - CLEAR: wr_ready=0. One back-bank address written per cycle, counter 0..FB_W*FB_H-1. After the last address, -> IDLE and busy=0. A clear takes exactly FB_W*FB_H cycles (19200 at default). clear_req during CLEAR is ignored.
- Swap:
  - swap_req sets swap_pending (idempotent while pending).
  - Vblank-entry event = cycle where posY==SCREEN_Y && posX==0.
  - On the event with swap_pending=1 and FSM=IDLE: toggle front_sel, clear swap_pending, and pulse swap_done for 1 cycle.
  - If FSM=CLEAR at the event, the swap waits for the next vblank-entry with FSM=IDLE.
  - swap_req on the event cycle itself is honoured at that event.
  - A write on the swap cycle targets the pre-swap back bank.
- Reset mid-operation (clear or pending swap): FSM returns to IDLE, swap_pending=0, front_sel=0. RAM keeps whatever was written.
- Widths: address is 15 bits (FB_W*FB_H-1=19199 < 2^15). The posX/posY shift is applied before the multiply. No arithmetic wrap is possible within the parameter defaults.

Test Plan:
- Reset, clear_req with clear_color=3'b101 -> busy high for exactly 19200 cycles, wr_ready=0 throughout; after swap at the next vblank, every visible pixel_out=3'b101.
- Write (10,20)=3'b011, swap, then scan posX=40..43 and posY=80..83 -> pixel_out=3'b011 one cycle later for all 16 positions, and neighbours hold the clear colour.
- posX=640 or posY=480 stimulus -> pixel_out=0 regardless of RAM contents.
- swap_req at posY=100 -> front_sel unchanged until the cycle posY=480,posX=0; swap_done is a single 1-cycle pulse there and swap_pending drops.
- swap_req during CLEAR spanning a vblank-entry -> no swap at that event; swap occurs at the first vblank-entry after busy falls.
- Write to (200,5) -> handshake completes and no RAM location changes. Assert rst mid-clear -> busy=0, wr_ready=1, front_sel=0 immediately (asynchronously).
